// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter that shares one W-bit adder among N_REQ
// requesters and holds each result in a one-entry output stage.
module add_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 32,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W-1:0]         res_sum,
  output logic                 res_carry,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          op_count
);

  localparam int unsigned NR = N_REQ;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_last;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic [IDW-1:0]   r_id;
  logic [31:0]      r_op_count;

  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_grant_idx;
  logic             w_found;
  logic             w_can_accept;
  logic             w_accept;
  logic [W-1:0]     w_opa;
  logic [W-1:0]     w_opb;
  logic [W:0]       w_sum_full;

  assign w_can_accept = (r_state == EMPTY) | res_ready;

  // Round-robin search starting one past the last accepted requester
  always_comb begin
    int unsigned idx;
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = 32'(r_last) + k;
      if (idx >= NR) idx = idx - NR;
      if (!w_found && req_valid[idx]) begin
        w_found      = 1'b1;
        w_grant[idx] = 1'b1;
        w_grant_idx  = IDW'(idx);
      end
    end
  end

  // Ready is held off while in reset even though the grant decode is live
  assign req_ready = w_grant & {N_REQ{w_can_accept & rst_n}};
  assign w_accept  = w_found & w_can_accept & rst_n;

  assign w_opa      = req_a[w_grant_idx*W +: W];
  assign w_opb      = req_b[w_grant_idx*W +: W];
  assign w_sum_full = {1'b0, w_opa} + {1'b0, w_opb};

  // Output-stage FSM, result registers, round-robin pointer and transfer count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_last     <= IDW'(N_REQ - 1);
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_id       <= '0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_state <= FULL;
        r_sum   <= w_sum_full[W-1:0];
        r_carry <= w_sum_full[W];
        r_id    <= w_grant_idx;
        r_last  <= w_grant_idx;
      end else if (res_ready) begin
        r_state <= EMPTY;
      end
      if ((r_state == FULL) && res_ready) begin
        r_op_count <= r_op_count + 32'd1;
      end
    end
  end

  assign res_valid = (r_state == FULL);
  assign res_sum   = r_sum;
  assign res_carry = r_carry;
  assign res_id    = r_id;
  assign op_count  = r_op_count;

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter and sequencer that shares one 32-bit adder among several requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle, registers the sum, carry-out and requester ID into a one-entry output stage, and hands the result downstream with its own valid/ready handshake. It sits between the ALU's adder datapath and its clients, such as the PC incrementer, address generator and accumulator.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 32: operand/sum width.
- `IDW`, default `$clog2(N_REQ)`: width of `res_id`.

- `clk`  in  1  : single clock; all state updates on its rising edge.
- `rst_n`  in  1  : asynchronous active-low reset.
- `req_valid`  in  `N_REQ`  : bit i set means requester i presents an operand pair.
- `req_a`  in  `N_REQ*W`  : operand A; requester i at bits `[i*W +: W]`.
- `req_b`  in  `N_REQ*W`  : operand B; same packing as `req_a`.
- `req_ready`  out  `N_REQ`  : one-hot or zero; bit i set means requester i's pair is accepted this cycle.
- `res_valid`  out  1  : output stage holds a result.
- `res_ready`  in  1  : downstream accepts the result.
- `res_sum`  out  `W`  : `(a + b) mod 2^W`.
- `res_carry`  out  1  : carry-out of bit `W-1`.
- `res_id`  out  `IDW`  : index of the requester that produced `res_sum`.
- `op_count`  out  32  : count of completed result transfers; wraps `2^32-1` to 0.

## Operation
- Output-stage FSM:
  - EMPTY (`res_valid`=0) moves to FULL on accept.
  - FULL moves to EMPTY when `res_ready` is high and there is no accept.
  - FULL stays FULL when `res_ready` and an accept occur together (back-to-back).
- Stall signal `can_accept = ~res_valid | res_ready` (combinational).
- Grant is combinational round-robin over `req_valid`:
  - Search starts at `(last+1) mod N_REQ`; the first valid index wins.
  - `last` resets to `N_REQ-1`, so requester 0 has top priority after reset.
- `req_ready[i] = grant[i] & can_accept`.
- Accept means `req_valid[i] & req_ready[i]`. On accept, at the clock edge:
  - `res_sum`, `res_carry` and `res_id` are loaded from requester i's operands.
  - `last` is set to i.
- `last` updates only on accept, never on a stalled grant.
- Requester obligations: hold `req_valid`, `req_a` and `req_b` stable until accepted.
- A requester may drop `req_valid` before acceptance. The grant then moves on and no result is produced for it.
- Arithmetic: unsigned ripple add, `W+1`-bit result; the low `W` bits go to `res_sum`, the top bit to `res_carry`. Overflow wraps silently.
- Output obligations: `res_sum`, `res_carry` and `res_id` stay stable while `res_valid & ~res_ready`.
- `op_count` increments by 1 on each `res_valid & res_ready` edge.
- Reset (asynchronous, any time including mid-transfer): an in-flight result is discarded, not delivered.
  - `res_valid`=0, `res_sum`=0, `res_carry`=0, `res_id`=0.
  - `op_count`=0, `last`=`N_REQ-1`.
  - `req_ready` is 0 while `rst_n` is low.
- `req_ready` and grant decode have no combinational path from `req_a`/`req_b`.

## Timing
- Latency: an accept at edge T makes the result visible with `res_valid`=1 immediately after edge T (1 cycle).
- Throughput: one result per cycle while downstream holds `res_ready`=1 and at least one `req_valid` is asserted.
- Stall: FULL with `res_ready`=0 forces all `req_ready` to 0 and holds `last` unchanged.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,`N_REQ-1`,0…. No requester waits more than `N_REQ-1` accepts.
- Rising edge of `rst_n` is synchronised externally. The first grant can occur on the first edge after release.

## Test plan
- Single op: reset, then requester 2 presents a=`0x0000_0005`, b=`0x0000_0007`, `res_ready`=1.
  - `req_ready`=`4'b0100` in the same cycle.
  - Next cycle: `res_valid`=1, `res_sum`=`0x0000_000C`, `res_carry`=0, `res_id`=2, then `op_count`=1.
- Wrap: a=`0xFFFF_FFFF`, b=`0x0000_0001` gives `res_sum`=0, `res_carry`=1. A second op with a=b=`0x8000_0000` gives `res_sum`=0, `res_carry`=1.
- Round-robin: all 4 requesters valid for 8 cycles with `res_ready`=1 gives `res_id` sequence 0,1,2,3,0,1,2,3 and `op_count`=8.
- Backpressure: hold `res_ready`=0 for 3 cycles after the first result.
  - `req_ready`=0 throughout; `res_*` stay stable.
  - On `res_ready`=1, the next grant is the requester after the last one served, with no result lost or duplicated.
- Withdrawal: requester 1 valid but stalled, then it drops `req_valid` while requester 3 is valid. Requester 3 is served next and no result ever has `res_id`=1.
- Reset mid-op: assert `rst_n`=0 while `res_valid`=1.
  - All outputs go to 0 immediately, without waiting for a clock.
  - After release, requester 0 wins when all requesters are valid.
